// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word and presents it
// with a sequential byte address on a registered valid/ready output slot.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_op,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic        restart,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        full,
    output logic        err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    opcode_e       opcode;
    logic [31:0]   enc_word;
    logic          enc_illegal;
    logic          enc_misalign;
    logic          fire;
    logic [31:0]   word_offset;

    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          err_q, err_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_instr_q, out_instr_d;
    logic [31:0]   out_addr_q, out_addr_d;

    always_comb begin
        opcode       = opcode_e'(in_op);
        enc_word     = NOP_WORD;
        enc_illegal  = 1'b0;
        enc_misalign = 1'b0;
        case (opcode)
            OP_REG: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
            OP_IMM: begin
                // Shift-immediates carry funct7 in the upper bits instead of imm[11:5].
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
                    enc_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_op};
                end else begin
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
                end
            end
            OP_LOAD, OP_JALR, OP_SYSTEM:
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
            OP_STORE:
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
            OP_BRANCH: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_op};
                enc_misalign = in_imm[0];
            end
            OP_LUI, OP_AUIPC:
                enc_word = {in_imm[31:12], in_rd, in_op};
            OP_JAL: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
                enc_misalign = in_imm[0];
            end
            default: enc_illegal = 1'b1;
        endcase
    end

    assign in_ready    = !full_q && !restart && (!out_valid_q || out_ready);
    assign fire        = in_valid && in_ready;
    assign word_offset = 32'(count_q) << 2;

    always_comb begin
        count_d     = count_q;
        full_d      = full_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        if (fire) begin
            out_valid_d = 1'b1;
            out_instr_d = enc_word;
            out_addr_d  = BASE_ADDR + word_offset;
            count_d     = count_q + CW'(1);
            if (count_d == DEPTH_C) begin
                full_d = 1'b1;
            end
            if (enc_illegal || enc_misalign) begin
                err_d = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (restart) begin
            count_d = '0;
            full_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= BASE_ADDR;
        end else begin
            count_q     <= count_d;
            full_q      <= full_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign full      = full_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a small DEPTH=4 instance and a wrapping-address DEPTH=256
// instance share one stimulus stream and are both checked against a field-level model.
module tb_instr_encoder;

    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'hFFFF_FFF8;
    localparam int unsigned DEP0  = 4;
    localparam int unsigned DEP1  = 256;

    logic        clk = 1'b0;
    logic        rst, restart, in_valid, out_ready;
    logic [6:0]  in_op, in_funct7;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;

    logic [1:0]       rdy_w, val_w, full_w, err_w;
    logic [1:0][31:0] instr_w, addr_w;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(BASE0), .DEPTH(DEP0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[0]),
        .in_op(in_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .restart(restart), .out_valid(val_w[0]), .out_ready(out_ready),
        .out_instr(instr_w[0]), .out_addr(addr_w[0]), .full(full_w[0]), .err(err_w[0])
    );

    instr_encoder #(.BASE_ADDR(BASE1), .DEPTH(DEP1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[1]),
        .in_op(in_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .restart(restart), .out_valid(val_w[1]), .out_ready(out_ready),
        .out_instr(instr_w[1]), .out_addr(addr_w[1]), .full(full_w[1]), .err(err_w[1])
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", name, idx, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_enc(input logic [6:0] op, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [31:0] imm);
        logic [31:0] o, a, b, c, d, e, f;
        o = 32'(op); a = 32'(f3) << 12; b = 32'(f7) << 25;
        c = 32'(rd) << 7; d = 32'(rs1) << 15; e = 32'(rs2) << 20;
        f = 32'(0);
        case (op)
            7'h33: f = b | e | d | a | c | o;
            7'h13: if (f3 == 3'd1 || f3 == 3'd5) f = b | ((imm % 32) << 20) | d | a | c | o;
                   else f = ((imm & 32'hFFF) << 20) | d | a | c | o;
            7'h03, 7'h67, 7'h73: f = ((imm & 32'hFFF) << 20) | d | a | c | o;
            7'h23: f = (((imm >> 5) & 32'h7F) << 25) | e | d | a | ((imm & 32'h1F) << 7) | o;
            7'h63: f = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | e | d | a
                     | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | o;
            7'h37, 7'h17: f = (imm & 32'hFFFF_F000) | c | o;
            7'h6F: f = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                     | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | c | o;
            default: f = 32'h0000_0013;
        endcase
        return f;
    endfunction

    function automatic logic model_bad(input logic [6:0] op, input logic [31:0] imm);
        logic known;
        known = (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h67) ||
                (op == 7'h73) || (op == 7'h23) || (op == 7'h63) || (op == 7'h37) ||
                (op == 7'h17) || (op == 7'h6F);
        return !known || ((op == 7'h63 || op == 7'h6F) && imm[0]);
    endfunction

    function automatic logic [31:0] base_of(input int i);
        return (i == 0) ? BASE0 : BASE1;
    endfunction

    function automatic int unsigned depth_of(input int i);
        return (i == 0) ? DEP0 : DEP1;
    endfunction

    logic             live = 1'b0;
    logic [1:0]       m_valid, m_err;
    logic [1:0][31:0] m_instr, m_addr;
    int unsigned      m_count [2];

    // The model's full flag is simply "count has reached DEPTH".
    function automatic logic m_ready(input int i);
        return (m_count[i] != depth_of(i)) && !restart && (!m_valid[i] || out_ready);
    endfunction

    always @(posedge clk) begin
        live <= 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_valid[i] <= 1'b0;
                m_instr[i] <= '0;
                m_addr[i]  <= base_of(i);
                m_count[i] <= 0;
                m_err[i]   <= 1'b0;
            end else begin
                if (in_valid && m_ready(i)) begin
                    m_valid[i] <= 1'b1;
                    m_instr[i] <= model_enc(in_op, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
                    m_addr[i]  <= base_of(i) + 32'(4 * m_count[i]);
                    m_count[i] <= restart ? 0 : m_count[i] + 1;
                    if (model_bad(in_op, in_imm)) m_err[i] <= 1'b1;
                end else begin
                    if (out_ready) m_valid[i] <= 1'b0;
                    if (restart) m_count[i] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            for (int i = 0; i < 2; i++) begin
                chk("out_valid", i, 32'(val_w[i]), 32'(m_valid[i]));
                chk("in_ready", i, 32'(rdy_w[i]), 32'(m_ready(i)));
                chk("full", i, 32'(full_w[i]), 32'(m_count[i] == depth_of(i)));
                chk("err", i, 32'(err_w[i]), 32'(m_err[i]));
                chk("out_instr", i, instr_w[i], m_instr[i]);
                chk("out_addr", i, addr_w[i], m_addr[i]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t stream [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        in_valid = 1'b1; in_op = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    task automatic pulse_rst();
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stream[0] = '{7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,          32'h0020_81B3};
        stream[1] = '{7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020_A423};
        stream[2] = '{7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020_8463};
        stream[3] = '{7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd16,         32'h0100_00EF};
        stream[4] = '{7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7};
        stream[5] = '{7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 32'd3,          32'h4030_D093};

        rst = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_funct3 = '0; in_funct7 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("lit_rst_valid", 0, 32'(val_w[0]), 32'd0);
        chk("lit_rst_instr", 0, instr_w[0], 32'd0);
        chk("lit_rst_addr", 1, addr_w[1], BASE1);
        #1;

        // addi x1, x0, 5: one-cycle latency
        drive(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lit_addi_valid", 0, 32'(val_w[0]), 32'd1);
        chk("lit_addi_instr", 0, instr_w[0], 32'h0050_0093);
        chk("lit_addi_addr", 0, addr_w[0], 32'h0);
        #1;
        step();
        restart = 1'b1;
        step();
        restart = 1'b0;

        // back-to-back stream; instance 0 fills after four words
        for (int k = 0; k < 6; k++) begin
            drive(stream[k].op, stream[k].f3, stream[k].f7, stream[k].rd,
                  stream[k].rs1, stream[k].rs2, stream[k].imm);
            step();
            @(negedge clk);
            chk("lit_stream_instr", 1, instr_w[1], stream[k].exp);
            chk("lit_stream_addr", 1, addr_w[1], BASE1 + 32'(4 * k));
            if (k < 4) chk("lit_stream_addr", 0, addr_w[0], 32'(4 * k));
            if (k >= 3) chk("lit_full_rdy", 0, 32'(rdy_w[0]), 32'd0);
            #1;
        end
        chk("lit_full", 0, 32'(full_w[0]), 32'd1);

        // restart blocks a same-cycle fire, then releases full
        drive(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
        restart = 1'b1;
        @(negedge clk);
        chk("lit_restart_rdy", 1, 32'(rdy_w[1]), 32'd0);
        #1;
        step();
        restart = 1'b0;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lit_restart_full", 0, 32'(full_w[0]), 32'd0);
        chk("lit_restart_addr", 0, addr_w[0], 32'h0);
        chk("lit_restart_addr", 1, addr_w[1], BASE1);
        #1;

        // backpressure with a pending bundle
        out_ready = 1'b0;
        drive(7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            chk("lit_bp_rdy", 0, 32'(rdy_w[0]), 32'd0);
            chk("lit_bp_instr", 0, instr_w[0], 32'h0050_0093);
            chk("lit_bp_addr", 0, addr_w[0], 32'h0);
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("lit_bp_release_rdy", 0, 32'(rdy_w[0]), 32'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lit_bp_new_instr", 0, instr_w[0], 32'h0010_0113);
        chk("lit_bp_new_addr", 0, addr_w[0], 32'h4);
        #1;

        // misaligned branch and jump, illegal opcode, err stickiness
        pulse_rst();
        drive(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd7);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lit_br_odd_instr", 0, instr_w[0], 32'h0020_8363);
        chk("lit_br_odd_err", 0, 32'(err_w[0]), 32'd1);
        #1;
        pulse_rst();
        drive(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h11);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lit_jal_odd_instr", 0, instr_w[0], 32'h0100_006F);
        #1;
        pulse_rst();
        drive(7'h00, 3'd0, 7'h00, 5'd7, 5'd3, 5'd4, 32'h55);
        step();
        drive(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
        @(negedge clk);
        chk("lit_illegal_instr", 0, instr_w[0], 32'h0000_0013);
        chk("lit_illegal_err", 0, 32'(err_w[0]), 32'd1);
        #1;
        step();
        in_valid = 1'b0;
        restart = 1'b1;
        step();
        restart = 1'b0;
        @(negedge clk);
        chk("lit_err_sticky", 0, 32'(err_w[0]), 32'd1);
        #1;

        // reset while a word is held under backpressure
        out_ready = 1'b0;
        drive(7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        in_valid = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lit_midrst_valid", 0, 32'(val_w[0]), 32'd0);
        chk("lit_midrst_addr", 0, addr_w[0], BASE0);
        chk("lit_midrst_err", 0, 32'(err_w[0]), 32'd0);
        #1;
        out_ready = 1'b1;
        drive(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lit_midrst_count", 1, addr_w[1], BASE1);
        #1;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
